// File: rtl/rc4_pkg.sv
// rc4_pkg: shared types and constants for the RC4 decrypt stage.
// Text bounds are used only when PRGA_ASCII_CHECK_EN is defined.
package rc4_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [3:0] {
        IDLE,
        I_ADDR,
        I_WAIT,
        I_READ,
        J_ADDR,
        J_WAIT,
        J_READ,
        WR_I,
        WR_J,
        F_ADDR,
        F_WAIT,
        F_READ,
        WR_D,
        DONE
    } prga_state_t;

    typedef struct packed {
        logic clr;
        logic inc_i;
        logic ld_si;
        logic ld_sj;
        logic ld_f;
        logic inc_k;
    } dp_ctrl_t;

    localparam byte_t ASCII_LO = 8'd97;
    localparam byte_t ASCII_HI = 8'd122;
    localparam byte_t ASCII_SP = 8'd32;

    function automatic logic is_text(byte_t b);
        return ((b >= ASCII_LO) && (b <= ASCII_HI)) || (b == ASCII_SP);
    endfunction

endpackage

// File: rtl/prga_datapath.sv
// prga_datapath: i/j/k counters, si/sj/f/enc registers and the
// S RAM / message address and data muxes for the RC4 stage.
module prga_datapath
    import rc4_pkg::*;
#(
    parameter int ROM_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  prga_state_t       state,
    input  dp_ctrl_t          ctrl,
    input  logic [7:0]        s_data_in,
    input  logic [7:0]        rom_data,
    output logic [7:0]        s_address,
    output logic [7:0]        s_data_out,
    output logic [ROM_AW-1:0] rom_address,
    output logic [ROM_AW-1:0] d_address,
    output logic [7:0]        d_data
);

    byte_t i_q, i_d;
    byte_t j_q, j_d;
    byte_t si_q, si_d;
    byte_t sj_q, sj_d;
    byte_t f_q, f_d;
    byte_t enc_q, enc_d;
    byte_t addr_q, addr_d;
    logic [ROM_AW-1:0] k_q, k_d;

    always_comb begin
        i_d    = i_q;
        j_d    = j_q;
        k_d    = k_q;
        si_d   = si_q;
        sj_d   = sj_q;
        f_d    = f_q;
        enc_d  = enc_q;
        addr_d = addr_q;
        if (ctrl.clr) begin
            i_d = '0;
            j_d = '0;
            k_d = '0;
        end
        if (ctrl.inc_i) i_d = i_q + 8'd1;
        if (ctrl.ld_si) begin
            si_d  = s_data_in;
            j_d   = j_q + s_data_in;
            enc_d = rom_data;
        end
        if (ctrl.ld_sj) sj_d = s_data_in;
        if (ctrl.ld_f)  f_d  = s_data_in;
        if (ctrl.inc_k) k_d  = k_q + ROM_AW'(1);
        // Address is registered: computed one state ahead of its use.
        unique case (state)
            I_ADDR:  addr_d = i_q + 8'd1;
            J_ADDR:  addr_d = j_q;
            J_READ:  addr_d = i_q;
            WR_I:    addr_d = j_q;
            F_ADDR:  addr_d = si_q + sj_q;
            default: addr_d = addr_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            i_q    <= '0;
            j_q    <= '0;
            k_q    <= '0;
            si_q   <= '0;
            sj_q   <= '0;
            f_q    <= '0;
            enc_q  <= '0;
            addr_q <= '0;
        end else begin
            i_q    <= i_d;
            j_q    <= j_d;
            k_q    <= k_d;
            si_q   <= si_d;
            sj_q   <= sj_d;
            f_q    <= f_d;
            enc_q  <= enc_d;
            addr_q <= addr_d;
        end
    end

    assign s_address   = addr_q;
    assign rom_address = k_q;
    assign d_address   = k_q;
    assign s_data_out  = (state == WR_I) ? sj_q :
                         (state == WR_J) ? si_q : 8'd0;
    assign d_data      = (state == WR_D) ? (f_q ^ enc_q) : 8'd0;

endmodule

// File: rtl/prga_decrypt.sv
// prga_decrypt: RC4 PRGA + XOR decrypt, 12 cycles per message byte.
// Define PRGA_ASCII_CHECK_EN to abort on a decrypted non-text byte.
module prga_decrypt
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = 32,
    parameter int ROM_AW  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        s_data_in,
    output logic [7:0]        s_address,
    output logic [7:0]        s_data_out,
    output logic              s_wren,
    input  logic [7:0]        rom_data,
    output logic [ROM_AW-1:0] rom_address,
    output logic [ROM_AW-1:0] d_address,
    output logic [7:0]        d_data,
    output logic              d_wren,
    output logic              finish,
    output logic              fail
);

    localparam logic [ROM_AW-1:0] K_LAST = ROM_AW'(MSG_LEN - 1);

    prga_state_t state_q, state_d;
    dp_ctrl_t    ctrl;
    logic        last;
    logic        bad;

    prga_datapath #(.ROM_AW(ROM_AW)) u_dp (
        .clk        (clk),
        .reset      (reset),
        .state      (state_q),
        .ctrl       (ctrl),
        .s_data_in  (s_data_in),
        .rom_data   (rom_data),
        .s_address  (s_address),
        .s_data_out (s_data_out),
        .rom_address(rom_address),
        .d_address  (d_address),
        .d_data     (d_data)
    );

    assign last = (d_address == K_LAST);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = I_ADDR;
            I_ADDR:  state_d = I_WAIT;
            I_WAIT:  state_d = I_READ;
            I_READ:  state_d = J_ADDR;
            J_ADDR:  state_d = J_WAIT;
            J_WAIT:  state_d = J_READ;
            J_READ:  state_d = WR_I;
            WR_I:    state_d = WR_J;
            WR_J:    state_d = F_ADDR;
            F_ADDR:  state_d = F_WAIT;
            F_WAIT:  state_d = F_READ;
            F_READ:  state_d = WR_D;
            WR_D:    state_d = (last || bad) ? DONE : I_ADDR;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are masked while reset is high so no write lands mid-reset.
    always_comb begin
        ctrl   = '0;
        s_wren = 1'b0;
        d_wren = 1'b0;
        finish = 1'b0;
        unique case (state_q)
            IDLE:    ctrl.clr   = start;
            I_ADDR:  ctrl.inc_i = 1'b1;
            I_READ:  ctrl.ld_si = 1'b1;
            J_READ:  ctrl.ld_sj = 1'b1;
            WR_I:    s_wren     = !reset;
            WR_J:    s_wren     = !reset;
            F_READ:  ctrl.ld_f  = 1'b1;
            WR_D: begin
                d_wren     = !reset;
                ctrl.inc_k = !last;
            end
            DONE:    finish     = !reset;
            default: ;
        endcase
    end

`ifdef PRGA_ASCII_CHECK_EN
    logic fail_q, fail_d;

    assign bad = (state_q == WR_D) && !is_text(d_data);

    always_comb begin
        fail_d = fail_q;
        if (state_q == IDLE && start) fail_d = 1'b0;
        if (bad)                      fail_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) fail_q <= 1'b0;
        else       fail_q <= fail_d;
    end

    assign fail = fail_q;
`else
    assign bad  = 1'b0;
    assign fail = 1'b0;
`endif

endmodule
